// File: rtl/dmac_channel_scheduler.sv
// Two-channel DMAC sequencing controller: arbitrates peripheral requests, acquires
// the AHB bus, enables the selected datapath channel and supervises completion.
module dmac_channel_scheduler #(
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] DmacReq,
    input  logic       C_config,
    input  logic       irq,
    input  logic       HGrant,
    input  logic       HReadyOut,
    input  logic [1:0] HResp,
    output logic       HBusReq,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic       con_en,
    output logic       con_sel,
    output logic [1:0] DmacAck,
    output logic       dma_err,
    output logic       busy
);

    // state   | meaning
    // IDLE    | waiting for a configured request, arbitration happens here
    // BUS_REQ | requesting the AHB bus for the selected channel
    // XFER    | channel enabled, watchdog counting
    // PAUSE   | grant lost, channel disabled, watchdog frozen
    // DONE    | one-cycle acknowledge to the peripheral
    // ABORT   | one-cycle error pulse after bus error or timeout
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BUS_REQ = 3'd1;
    localparam logic [2:0] XFER    = 3'd2;
    localparam logic [2:0] PAUSE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] ABORT   = 3'd5;

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             sel_q;
    logic             last_sel;
    logic             con_en_q;
    logic [CNT_W-1:0] watchdog;
    logic             req_sel;
    logic             bus_err;
    logic             granted;
    logic             timeout;

    assign bus_err = (HResp == 2'b01);
    assign granted = HGrant && HReadyOut;
    assign timeout = (watchdog == WD_LIMIT);

    always_comb begin
        req_sel = 1'b0;
        case (DmacReq)
            2'b01:   req_sel = 1'b0;
            2'b10:   req_sel = 1'b1;
            2'b11:   req_sel = (ROUND_ROBIN != 0) ? ~last_sel : 1'b0;
            default: req_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (C_config && (DmacReq != 2'b00)) state_nxt = BUS_REQ;
            BUS_REQ: if (granted) state_nxt = XFER;
            XFER: begin
                if (bus_err)      state_nxt = ABORT;
                else if (irq)     state_nxt = DONE;
                else if (timeout) state_nxt = ABORT;
                else if (!HGrant) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (bus_err)      state_nxt = ABORT;
                else if (irq)     state_nxt = DONE;
                else if (granted) state_nxt = XFER;
            end
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= 1'b0;
            last_sel <= 1'b1;
            con_en_q <= 1'b0;
            watchdog <= '0;
        end else begin
            state    <= state_nxt;
            con_en_q <= (state == IDLE) && (state_nxt == BUS_REQ);
            if ((state == IDLE) && (state_nxt == BUS_REQ))
                sel_q <= req_sel;
            if ((state == DONE) || (state == ABORT))
                last_sel <= sel_q;
            // Cleared on the way out of XFER so the count never reaches the limit value + 1.
            if (state == XFER) begin
                if ((state_nxt == XFER) || (state_nxt == PAUSE))
                    watchdog <= watchdog + 1'b1;
                else
                    watchdog <= '0;
            end else if (state != PAUSE) begin
                watchdog <= '0;
            end
        end
    end

    assign HBusReq      = (state == BUS_REQ) || (state == XFER) || (state == PAUSE);
    assign channel_en_1 = (state == XFER) && !sel_q;
    assign channel_en_2 = (state == XFER) && sel_q;
    assign con_en       = con_en_q;
    assign con_sel      = sel_q;
    assign DmacAck      = (state == DONE) ? {sel_q, ~sel_q} : 2'b00;
    assign dma_err      = (state == ABORT);
    assign busy         = (state != IDLE);

endmodule
